// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage; one quotient bit per clock.
// Optional DIV_BYZERO_FLAG_EN adds the div_byzero output flagging a zero divisor.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
`ifdef DIV_BYZERO_FLAG_EN
    output logic                 div_byzero,
`endif
    output logic                 stallreq
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? twos_neg(v) : v;
    endfunction

    logic [1:0]           state_q,   state_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [WIDTH-1:0]     rem_q,     rem_d;
    logic [WIDTH-1:0]     quo_q,     quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;
    logic                 ready_q,   ready_d;
`ifdef DIV_BYZERO_FLAG_EN
    logic                 byzero_q,  byzero_d;
`endif

    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       diff_s;
    logic                 ge_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // One restoring step; the partial remainder is always below the divisor,
    // so bit WIDTH of the (WIDTH+1)-bit difference is exactly the borrow.
    always_comb begin
        rem_sh_s  = {rem_q, quo_q[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, divisor_q};
        ge_s      = ~diff_s[WIDTH];
        quo_fix_s = neg_quo_q ? twos_neg(quo_q) : quo_q;
        rem_fix_s = neg_rem_q ? twos_neg(rem_q) : rem_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
        byzero_d  = byzero_q;
`endif
        if (annul) begin
            state_d  = S_IDLE;
            cnt_d    = {CW{1'b0}};
            result_d = {(2*WIDTH){1'b0}};
            ready_d  = 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            byzero_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_d = 1'b0;
                    if (start) begin
                        cnt_d = {CW{1'b0}};
                        if (opdata2 == {WIDTH{1'b0}}) begin
                            state_d = S_BYZERO;
                        end else begin
                            state_d   = S_ON;
                            rem_d     = {WIDTH{1'b0}};
                            quo_d     = magnitude(opdata1, signed_div);
                            divisor_d = magnitude(opdata2, signed_div);
                            neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            neg_rem_d = signed_div & opdata1[WIDTH-1];
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                // Two edges here so a zero divisor reports ready after E2.
                S_BYZERO: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        cnt_d = {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_d  = S_END;
                        cnt_d    = {CW{1'b0}};
                        result_d = {(2*WIDTH){1'b0}};
                        ready_d  = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                        byzero_d = 1'b1;
`endif
                    end
                end
                S_ON: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        state_d  = S_END;
                        result_d = {rem_fix_s, quo_fix_s};
                        ready_d  = 1'b1;
                    end else begin
                        rem_d = ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], ge_s};
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_END: begin
                    if (!start) begin
                        state_d  = S_IDLE;
                        result_d = {(2*WIDTH){1'b0}};
                        ready_d  = 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                        byzero_d = 1'b0;
`endif
                    end else begin
                        state_d = S_END;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    result_d = {(2*WIDTH){1'b0}};
                    ready_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {(2*WIDTH){1'b0}};
            ready_q   <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
            byzero_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_BYZERO_FLAG_EN
            byzero_q  <= byzero_d;
`endif
        end
    end

    // Stall is combinational so ex holds in the request cycle; masked while in reset.
    assign stallreq = rst & ((state_q == S_ON) | (state_q == S_BYZERO) |
                             ((state_q == S_IDLE) & start & ~annul));
    assign result   = result_q;
    assign ready    = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
    assign div_byzero = byzero_q;
`endif

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed fixups, divide by zero, annul and async reset.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;
`ifdef DIV_BYZERO_FLAG_EN
    logic        div_byzero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
`ifdef DIV_BYZERO_FLAG_EN
        .div_byzero (div_byzero),
`endif
        .stallreq   (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request and wait (bounded) for ready; the first edge after the call is E0.
    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int   lat;
        logic stall_ok;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1;
        chk({tag, "_stall_req"}, 64'(stallreq), 64'd1);
        lat      = -1;
        stall_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
            if (stallreq !== 1'b1) stall_ok = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        chk({tag, "_stall_done"}, 64'(stallreq), 64'd0);
    endtask

    task automatic release_op(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rel_ready"}, 64'(ready), 64'd0);
        chk({tag, "_rel_result"}, result, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
        chk({tag, "_rel_flag"}, 64'(div_byzero), 64'd0);
`endif
    endtask

    initial begin
        logic seen;

        #3;
        chk("rst_result", result, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        start = 1'b1;
        #1;
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33);
        chk("divu_100_7_result", result, {32'd2, 32'd14});
`ifdef DIV_BYZERO_FLAG_EN
        chk("divu_100_7_flag", 64'(div_byzero), 64'd0);
`endif
        opdata1 = 32'hDEAD_BEEF;
        opdata2 = 32'd0;
        @(posedge clk);
        #1;
        chk("divu_100_7_hold_ready", 64'(ready), 64'd1);
        chk("divu_100_7_hold_result", result, {32'd2, 32'd14});
        release_op("divu_100_7");

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        chk("div_m7_2_result", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_op("div_m7_2");

        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
        chk("div_7_m2_result", result, {32'h0000_0001, 32'hFFFF_FFFD});
        release_op("div_7_m2");

        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 2);
        chk("divu_5_0_result", result, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
        chk("divu_5_0_flag", 64'(div_byzero), 64'd1);
`endif
        release_op("divu_5_0");

        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        chk("div_ovf_result", result, {32'h0000_0000, 32'h8000_0000});
        release_op("div_ovf");

        // Annul after cnt reaches 10 (edge E10), dropping start with it.
        signed_div = 1'b0;
        opdata1    = 32'hFFFF_FFFF;
        opdata2    = 32'd1;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_stallreq", 64'(stallreq), 64'd0);
        chk("annul_result", result, 64'd0);
        annul = 1'b0;
        seen  = 1'b0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen = 1'b1;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33);
        chk("divu_9_3_result", result, {32'd0, 32'd3});
        release_op("divu_9_3");

        // Async reset between edges once cnt has reached 20.
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        chk("pre_rst_stallreq", 64'(stallreq), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_stallreq", 64'(stallreq), 64'd0);
        chk("midrst_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(ready), 64'd0);
        run_op("divu_1_1", 1'b0, 32'd1, 32'd1, 33);
        chk("divu_1_1_result", result, {32'd0, 32'd1});
        release_op("divu_1_1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
